// File: rtl/mips_cpu_wb_pkg.sv
// Shared types for the register-file writeback path: entry layout and field widths.
package mips_cpu_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // One queued register-file write; orwrite asks the file to OR data into the old value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
        logic                  orwrite;
    } wb_entry_t;

    localparam wb_entry_t WB_ENTRY_NONE = '0;

endpackage

// File: rtl/mips_cpu_wb_fifo.sv
// In-order writeback queue: up to two pushes and one pop per cycle, with
// per-slot valid flags and destination registers exported for hazard masking.
module mips_cpu_wb_fifo
    import mips_cpu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           push_count,
    input  wb_entry_t                            push_first,
    input  wb_entry_t                            push_second,
    input  logic                                 pop,
    output wb_entry_t                            head,
    output logic [CNT_W-1:0]                     count,
    output logic [DEPTH-1:0]                     entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_dst
);

    wb_entry_t [DEPTH-1:0] slots;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      wr_ptr_next_slot;

    assign wr_ptr_next_slot = wr_ptr + PTR_W'(1);

    // NOTE: non-blocking assignments on all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(push_count);
            count  <= count + CNT_W'(push_count) - CNT_W'(pop);
        end
    end

    // NOTE: slot storage is deliberately not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_count != 2'd0) begin
            slots[wr_ptr] <= push_first;
        end
        if (push_count == 2'd2) begin
            slots[wr_ptr_next_slot] <= push_second;
        end
    end

    assign head = slots[rd_ptr];

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
            entry_dst[i]   = slots[i].dst;
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_writeback.sv
// Writeback initiator: merges ALU and load results into one in-order queue that
// drains one write per cycle to the register file, and flags pending destinations.
module mips_cpu_regfile_writeback
    import mips_cpu_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        mem_or,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic        rf_orwrite,
    output logic [31:0] pending_mask,
    output logic        empty
);

    localparam logic [PTR_W:0] MEM_LIMIT = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0] ALU_LIMIT = (PTR_W + 1)'(DEPTH - 2);

    logic [PTR_W:0]                      count;
    logic [DEPTH-1:0]                    entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_dst;
    wb_entry_t                           head;
    wb_entry_t                           push_first;
    wb_entry_t                           push_second;
    logic [1:0]                          push_count;
    logic                                mem_push;
    logic                                alu_push;
    logic                                drain_active;

    // ALU only sees room for two so a same-cycle load can never overflow the queue.
    assign mem_ready = !reset && (count <= MEM_LIMIT);
    assign alu_ready = !reset && (count <= ALU_LIMIT);

    // Writes to r0 complete the handshake but are dropped here.
    assign mem_push = mem_valid && mem_ready && (mem_reg != '0);
    assign alu_push = alu_valid && alu_ready && (alu_reg != '0);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        push_first  = WB_ENTRY_NONE;
        push_second = WB_ENTRY_NONE;
        push_count  = {1'b0, mem_push} + {1'b0, alu_push};
        if (mem_push) begin
            push_first  = '{dst: mem_reg, data: mem_data, orwrite: mem_or};
            push_second = '{dst: alu_reg, data: alu_data, orwrite: 1'b0};
        end else begin
            push_first  = '{dst: alu_reg, data: alu_data, orwrite: 1'b0};
        end
    end

    mips_cpu_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_count  (push_count),
        .push_first  (push_first),
        .push_second (push_second),
        .pop         (drain_active),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_dst   (entry_dst)
    );

    assign drain_active    = !reset && (count != '0);
    assign rf_write_enable = drain_active;
    assign rf_write_reg    = drain_active ? head.dst     : '0;
    assign rf_write_data   = drain_active ? head.data    : '0;
    assign rf_orwrite      = drain_active ? head.orwrite : 1'b0;
    assign empty           = reset || (count == '0);

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !reset) begin
                pending_mask[entry_dst[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_mips_cpu_regfile_writeback.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a queue-based reference of the writeback path.
module tb_mips_cpu_regfile_writeback;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        orw;
    } m_entry_t;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_or;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rf_orwrite;
    logic [31:0] pending_mask;
    logic        empty;

    int errors = 0;
    int checks = 0;

    m_entry_t    q[$];
    logic [4:0]  dut_writes[$];
    logic        obs_we, obs_or, obs_empty, obs_alu_ready, obs_mem_ready;
    logic [4:0]  obs_reg;
    logic [31:0] obs_data, obs_mask;
    logic        last_acc_alu, last_acc_mem;

    mips_cpu_regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_reg         (alu_reg),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_reg         (mem_reg),
        .mem_data        (mem_data),
        .mem_or          (mem_or),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data),
        .rf_orwrite      (rf_orwrite),
        .pending_mask    (pending_mask),
        .empty           (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle against the reference, then advance both.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic mo, input logic rst);
        logic [31:0] exp_mask;
        int          n;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md; mem_or = mo;
        reset = rst;
        #3;
        obs_we = rf_write_enable; obs_reg = rf_write_reg; obs_data = rf_write_data;
        obs_or = rf_orwrite; obs_mask = pending_mask; obs_empty = empty;
        obs_alu_ready = alu_ready; obs_mem_ready = mem_ready;
        if (obs_we === 1'b1) dut_writes.push_back(obs_reg);
        n = q.size();
        exp_mask = '0;
        foreach (q[i]) exp_mask = exp_mask | (32'd1 << q[i].rd);
        if (rst) begin
            check("rst_we", {31'd0, obs_we}, 32'd0);
            check("rst_mask", obs_mask, 32'd0);
            check("rst_empty", {31'd0, obs_empty}, 32'd1);
            check("rst_alu_ready", {31'd0, obs_alu_ready}, 32'd0);
            check("rst_mem_ready", {31'd0, obs_mem_ready}, 32'd0);
        end else begin
            check("we", {31'd0, obs_we}, {31'd0, n > 0});
            check("wreg", {27'd0, obs_reg}, n > 0 ? {27'd0, q[0].rd} : 32'd0);
            check("wdata", obs_data, n > 0 ? q[0].data : 32'd0);
            check("worw", {31'd0, obs_or}, n > 0 ? {31'd0, q[0].orw} : 32'd0);
            check("mask", obs_mask, exp_mask);
            check("empty", {31'd0, obs_empty}, {31'd0, n == 0});
            check("alu_ready", {31'd0, obs_alu_ready}, {31'd0, n <= DEPTH - 2});
            check("mem_ready", {31'd0, obs_mem_ready}, {31'd0, n <= DEPTH - 1});
        end
        last_acc_mem = !rst && mv && (n <= DEPTH - 1);
        last_acc_alu = !rst && av && (n <= DEPTH - 2);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (n > 0) void'(q.pop_front());
            if (last_acc_mem && mr != 5'd0) q.push_back('{rd: mr, data: md, orw: mo});
            if (last_acc_alu && ar != 5'd0) q.push_back('{rd: ar, data: ad, orw: 1'b0});
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0]  a_reg;
        logic [31:0] a_data;
        logic        a_pend;
        logic        saw_stall;
        int          sent;
        int          budget;

        alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0; mem_or = 0;
        reset = 1;
        @(posedge clk); #1;

        // Reset with requests presented: nothing accepted.
        cycle(1'b1, 5'd9, 32'h1234, 1'b1, 5'd8, 32'h5678, 1'b0, 1'b1);
        cycle(1'b1, 5'd9, 32'h1234, 1'b1, 5'd8, 32'h5678, 1'b0, 1'b1);
        idle();
        check("post_reset_empty", {31'd0, obs_empty}, 32'd1);

        // Single ALU write.
        cycle(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        idle();
        check("single_reg", {27'd0, obs_reg}, 32'd5);
        check("single_data", obs_data, 32'h0000_00AA);
        check("single_mask", obs_mask, 32'h0000_0020);
        idle();
        check("single_drained", obs_mask, 32'd0);

        // Simultaneous sources: load goes first.
        cycle(1'b1, 5'd4, 32'h0000_2222, 1'b1, 5'd3, 32'h1111_0000, 1'b1, 1'b0);
        idle();
        check("simul_first_reg", {27'd0, obs_reg}, 32'd3);
        check("simul_first_or", {31'd0, obs_or}, 32'd1);
        check("simul_mask0", obs_mask, 32'h0000_0018);
        idle();
        check("simul_second_reg", {27'd0, obs_reg}, 32'd4);
        check("simul_mask1", obs_mask, 32'h0000_0010);
        idle();
        check("simul_mask2", obs_mask, 32'd0);

        // Backpressure: ALU regs 1..5 held until accepted, loads 10..12 fill the queue.
        dut_writes.delete();
        saw_stall = 0;
        sent = 0;
        budget = 0;
        while (sent < 5 && budget < 30) begin
            cycle(1'b1, 5'(sent + 1), 32'h100 + 32'(sent + 1),
                  budget < 3, 5'(10 + budget), 32'h200 + 32'(budget), 1'b0, 1'b0);
            if (!obs_alu_ready) saw_stall = 1;
            if (last_acc_alu) sent++;
            budget++;
        end
        check("bp_all_sent", sent, 5);
        check("bp_stall_seen", {31'd0, saw_stall}, 32'd1);
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            idle();
            budget++;
        end
        idle();
        check("bp_drained", {31'd0, obs_empty}, 32'd1);
        sent = 0;
        foreach (dut_writes[i]) begin
            if (dut_writes[i] >= 5'd1 && dut_writes[i] <= 5'd5) begin
                sent++;
                check("bp_order", {27'd0, dut_writes[i]}, sent);
            end
        end
        check("bp_alu_write_count", sent, 5);

        // Register 0 is accepted but dropped.
        cycle(1'b1, 5'd0, 32'h0000_DEAD, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        check("r0_ready", {31'd0, obs_alu_ready}, 32'd1);
        idle();
        check("r0_we", {31'd0, obs_we}, 32'd0);
        check("r0_empty", {31'd0, obs_empty}, 32'd1);

        // Same register twice: overwrite then OR-merge, in order.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_FF00, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_00FF, 1'b1, 1'b0);
        check("same_first_data", obs_data, 32'h0000_FF00);
        check("same_first_or", {31'd0, obs_or}, 32'd0);
        idle();
        check("same_second_data", obs_data, 32'h0000_00FF);
        check("same_second_or", {31'd0, obs_or}, 32'd1);
        check("same_mask_held", obs_mask, 32'h0000_0080);
        idle();
        check("same_mask_clear", obs_mask, 32'd0);

        // Reset mid-operation discards three queued entries.
        cycle(1'b1, 5'd2, 32'hA2, 1'b1, 5'd1, 32'hA1, 1'b0, 1'b0);
        cycle(1'b1, 5'd4, 32'hA4, 1'b1, 5'd3, 32'hA3, 1'b0, 1'b0);
        check("mid_queued", q.size(), 3);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        dut_writes.delete();
        idle();
        check("mid_after_we", {31'd0, obs_we}, 32'd0);
        check("mid_after_empty", {31'd0, obs_empty}, 32'd1);
        idle();
        idle();
        check("mid_no_stale_writes", dut_writes.size(), 0);

        // Random traffic honouring the hold-while-not-ready rule for both sources.
        a_pend = 0; a_reg = 0; a_data = 0;
        for (int c = 0; c < 400; c++) begin
            logic        mv;
            logic [4:0]  mr;
            logic [31:0] md;
            logic        mo;
            logic        rst;
            if (!a_pend && ($urandom_range(0, 2) != 0)) begin
                a_pend = 1;
                a_reg  = 5'($urandom_range(0, 7));
                a_data = $urandom;
            end
            if (!mem_valid || last_acc_mem) begin
                mv = ($urandom_range(0, 1) == 1);
                mr = 5'($urandom_range(0, 7));
                md = $urandom;
                mo = 1'($urandom);
            end else begin
                mv = mem_valid; mr = mem_reg; md = mem_data; mo = mem_or;
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle(a_pend, a_reg, a_data, mv, mr, md, mo, rst);
            if (last_acc_alu) a_pend = 0;
            if (last_acc_mem) mem_valid = 1'b0;
        end
        for (int c = 0; c < 8; c++) idle();
        check("final_empty", {31'd0, obs_empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
